// File: rtl/avr_serial_pkg.sv
`default_nettype none
// ============================================================================
// avr_serial_pkg : shared FSM state, baud divider helper and 8N1 constants
// Rev 1.0
// ============================================================================
package avr_serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

    function automatic int clks_per_bit(input int clk_rate, input int baud);
        return clk_rate / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_tx_fifo.sv
`default_nettype none
// ============================================================================
// serial_tx_fifo : single-clock FIFO, registered full/empty, writes dropped when full
// Rev 1.0
// ============================================================================
module serial_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_DEPTH = (AW + 1)'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("serial_tx_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             r_full;
    logic             r_empty;
    logic             w_wr;
    logic             w_rd;
    logic [AW:0]      w_count_nxt;

    assign w_wr = i_wr_en && !r_full;
    assign w_rd = i_rd_en && !r_empty;

    always_comb begin
        w_count_nxt = r_count;
        if (w_wr && !w_rd) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_wr && w_rd) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_DEPTH);
            r_empty <= (w_count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= i_din;
    end

    // First-word fall-through: head is visible while the FIFO is non-empty
    assign o_dout  = r_mem[r_rptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule
`default_nettype wire

// File: rtl/avr_serial_tx.sv
`default_nettype none
// ============================================================================
// avr_serial_tx : 8N1 UART transmitter to the AVR with input FIFO and busy flow control
// Rev 1.0
// ============================================================================
module avr_serial_tx
    import avr_serial_pkg::*;
#(
    parameter int CLK_RATE   = 50000000,
    parameter int BAUD       = 500000,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       wr_en,
    output logic       full,
    input  logic       avr_rx_busy,
    output logic       tx,
    output logic       busy
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_RATE, BAUD);
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] c_CNT_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    c_LAST_BIT = 3'(DATA_BITS - 1);

    if ((CLK_RATE % BAUD) != 0 || CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("avr_serial_tx: CLK_RATE/BAUD must be an integer of at least 2");
    end

    logic          r_sync1;
    logic          r_busy_s;
    tx_state_t     r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          r_in_frame;
    logic          r_busy;
    logic [7:0]    w_fifo_dout;
    logic          w_fifo_empty;
    logic          w_fifo_full;
    logic          w_pop;
    logic          w_bit_end;

    serial_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_wr_en (wr_en),
        .i_din   (din),
        .i_rd_en (w_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_busy_s <= 1'b0;
        end else begin
            r_sync1  <= avr_rx_busy;
            r_busy_s <= r_sync1;
        end
    end

    assign w_pop     = (r_state == IDLE) && !w_fifo_empty && !r_busy_s;
    assign w_bit_end = (r_cnt == c_CNT_MAX);

    // tx is driven from the state one cycle behind, so r_in_frame tracks the line, not the FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_tx       <= STOP_BIT;
            r_in_frame <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_in_frame <= (r_state != IDLE);
            r_busy     <= (r_state != IDLE) || r_in_frame || !w_fifo_empty;
            case (r_state)
                IDLE: begin
                    r_tx  <= STOP_BIT;
                    r_cnt <= '0;
                    if (w_pop) begin
                        r_shift <= w_fifo_dout;
                        r_state <= START;
                    end
                end
                START: begin
                    r_tx <= START_BIT;
                    if (w_bit_end) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        r_state   <= DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DATA: begin
                    r_tx <= r_shift[0];
                    if (w_bit_end) begin
                        r_cnt     <= '0;
                        r_shift   <= {1'b0, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx == c_LAST_BIT) r_state <= STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                STOP: begin
                    r_tx <= STOP_BIT;
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign tx   = r_tx;
    assign busy = r_busy;
    assign full = w_fifo_full;

endmodule
`default_nettype wire

// File: tb/tb_avr_serial_tx.sv
`default_nettype none
// ============================================================================
// tb_avr_serial_tx : scoreboard bench, UART line decoder pops expected bytes
// Rev 1.0
// ============================================================================
module tb_avr_serial_tx;

    localparam int CPB   = 100;
    localparam int FRAME = 10 * CPB + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic       avr_rx_busy;
    logic [7:0] din;
    logic       full;
    logic       tx;
    logic       busy;

    int         cyc      = 0;
    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] exp_q[$];
    int         start_q[$];

    avr_serial_tx #(
        .CLK_RATE   (50000000),
        .BAUD       (500000),
        .FIFO_DEPTH (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .wr_en       (wr_en),
        .full        (full),
        .avr_rx_busy (avr_rx_busy),
        .tx          (tx),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [7:0] b, input bit expect_tx);
        din   = b;
        wr_en = 1'b1;
        if (expect_tx) exp_q.push_back(b);
        step(1);
        wr_en = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && n < budget) begin
            step(1);
            n++;
        end
        check(name, 32'(n < budget), 1);
    endtask

    // Line monitor: samples mid-bit on the falling clock edge
    initial begin : monitor
        logic [9:0] bits;
        bit         aborted;
        int         ts;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0 || tx !== 1'b0) continue;
            ts      = cyc;
            aborted = 1'b0;
            for (int i = 0; i < 10; i++) begin
                repeat ((i == 0) ? CPB / 2 : CPB) begin
                    @(negedge clk);
                    if (rst !== 1'b0) aborted = 1'b1;
                end
                bits[i] = tx;
            end
            if (!aborted) begin
                start_q.push_back(ts);
                check("frame_pending", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    check("frame_data", bits[8:1], exp_q.pop_front());
                    check("start_bit", bits[0], 0);
                    check("stop_bit", bits[9], 1);
                end
            end
        end
    end

    initial begin : watchdog
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded 60000 cycles");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int lows;
        int f;
        rst         = 1'b1;
        wr_en       = 1'b0;
        din         = 8'h00;
        avr_rx_busy = 1'b0;
        step(3);
        check("rst_tx", tx, 1);
        check("rst_full", full, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        step(2);

        // Single byte: write lands on edge 0
        write(8'hA5, 1'b1);
        step(1);
        check("a5_tx_edge1", tx, 1);
        check("a5_busy_edge1", busy, 1);
        step(1);
        check("a5_tx_edge2", tx, 0);
        step(100);
        check("a5_bit0", tx, 1);
        step(100);
        check("a5_bit1", tx, 0);
        step(700);
        check("a5_stop", tx, 1);
        step(100);
        check("a5_busy_1002", busy, 1);
        step(1);
        check("a5_busy_1003", busy, 0);
        check("a5_drained", exp_q.size(), 0);

        // Burst into a held-off FIFO: 16 accepted, 17th dropped
        avr_rx_busy = 1'b1;
        step(4);
        for (int i = 0; i < 17; i++) begin
            write(8'(i), i < 16);
            if (i == 14) check("burst_full_15", full, 0);
            if (i == 15) check("burst_full_16", full, 1);
        end
        check("burst_full_17", full, 1);
        check("burst_tx_held", tx, 1);
        start_q.delete();
        avr_rx_busy = 1'b0;
        step(2);
        check("burst_full_before_pop", full, 1);
        step(1);
        check("burst_full_after_pop", full, 0);
        check("burst_tx_pre_start", tx, 1);
        step(1);
        check("burst_tx_start", tx, 0);
        wait_drain("burst_drain", 17000);
        check("burst_frames", start_q.size(), 16);
        for (int i = 1; i < start_q.size(); i++) begin
            check("burst_gap", start_q[i] - start_q[i-1], FRAME);
        end

        // Flow control
        avr_rx_busy = 1'b1;
        step(4);
        write(8'h3C, 1'b1);
        write(8'h81, 1'b1);
        lows = 0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (tx !== 1'b1) lows++;
        end
        check("fc_held_silent", lows, 0);
        avr_rx_busy = 1'b0;
        f = 0;
        while (tx !== 1'b0 && f < 4) begin
            step(1);
            f++;
        end
        check("fc_start_within_4", tx, 0);
        step(300);
        avr_rx_busy = 1'b1;
        step(2500);
        check("fc_one_frame_only", exp_q.size(), 1);
        check("fc_busy_held", busy, 1);
        check("fc_tx_idle", tx, 1);
        avr_rx_busy = 1'b0;
        wait_drain("fc_drain", 3000);

        // Write coinciding with the pop of the single queued byte
        avr_rx_busy = 1'b1;
        step(4);
        start_q.delete();
        write(8'h11, 1'b1);
        avr_rx_busy = 1'b0;
        step(2);
        write(8'h22, 1'b1);
        wait_drain("sim_drain", 3000);
        check("sim_frames", start_q.size(), 2);
        if (start_q.size() == 2) check("sim_gap", start_q[1] - start_q[0], FRAME);
        check("sim_full", full, 0);

        // Reset during data bit 4 of 0xFF with three bytes behind it
        avr_rx_busy = 1'b1;
        step(4);
        write(8'hFF, 1'b0);
        write(8'h01, 1'b0);
        write(8'h02, 1'b0);
        write(8'h03, 1'b0);
        avr_rx_busy = 1'b0;
        step(4);
        check("rf_start", tx, 0);
        step(550);
        check("rf_bit4", tx, 1);
        check("rf_busy_pre", busy, 1);
        rst = 1'b1;
        step(1);
        check("rf_tx", tx, 1);
        check("rf_busy", busy, 0);
        check("rf_full", full, 0);
        rst = 1'b0;
        lows = 0;
        for (int i = 0; i < 3000; i++) begin
            step(1);
            if (tx !== 1'b1) lows++;
        end
        check("rf_silent", lows, 0);
        check("rf_busy_after", busy, 0);
        check("rf_queue", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/avr_serial_tx.md
# avr_serial_tx

Byte-oriented UART transmitter driving the FPGA-to-AVR serial line (`avr_rx` pin) on the Mojo board, with a small input FIFO and AVR-side flow control via `avr_rx_busy`. It gives the FPGA logic a way to stream bytes, such as microphone-derived data, to the AVR, which forwards them over USB. It sits under the top level beside the clock generator and replaces the constant high-Z drive on `avr_rx`.

## Interface
- `CLK_RATE`, 50000000: system clock frequency in Hz.
- `BAUD`, 500000: serial bit rate; `CLKS_PER_BIT = CLK_RATE / BAUD` must be an integer ≥ 2 (elaboration-time check).
- `FIFO_DEPTH`, 16: input FIFO entries; power of two, ≥ 2.
- `clk`  in  1: 50 MHz system clock. Single clock domain.
- `rst`  in  1: synchronous, active-high reset.
- `din`  in  8: byte to transmit.
- `wr_en`  in  1: write `din` into the FIFO this cycle.
- `full`  out  1: FIFO full; writes are ignored while high.
- `avr_rx_busy`  in  1: AVR receive buffer full; asynchronous to `clk`.
- `tx`  out  1: serial output, connects to the `avr_rx` pin; idle high.
- `busy`  out  1: high while a frame is in progress or the FIFO is non-empty.

## Operation
- Frame format is 8N1, LSB first: start bit (0), `d[0]`..`d[7]`, stop bit (1). Each bit lasts exactly `CLKS_PER_BIT` cycles.
- `avr_rx_busy` passes through a 2-flop synchronizer before use (`busy_s`).
- FSM states:
  - `IDLE`: `tx`=1. If the FIFO is non-empty and `busy_s`=0, pop the head into the shift register and go to `START`.
  - `START`: `tx`=0 for one bit time, then go to `DATA`, bit index 0.
  - `DATA`: `tx`=`shift[0]`. On each bit-time end, shift right and increment the index. After index 7 completes, go to `STOP`.
  - `STOP`: `tx`=1 for one bit time, then go to `IDLE`.
- Flow control: `busy_s` only gates the start of a new frame. A frame already in progress always completes.
- FIFO write rule: a write is accepted iff `wr_en`=1 and the registered `full`=0 in the same cycle.
  - A write and a pop in the same cycle while full: the write is dropped.
  - Write and pop in the same cycle otherwise: both happen and the count is unchanged.
- Pointers wrap modulo `FIFO_DEPTH`. The count is `$clog2(FIFO_DEPTH)+1` bits wide.
- Bit counter counts 0..`CLKS_PER_BIT-1`. Width is `$clog2(CLKS_PER_BIT)`.

## Timing
- Reset values: `tx`=1, `full`=0, `busy`=0, FSM=`IDLE`, FIFO empty, synchronizer flops=0.
- Reset mid-frame: on the next edge `tx`=1 and the FIFO is emptied. Bytes in flight are discarded.
- Latency: write at edge 0 into an empty FIFO with the FSM idle and `busy_s`=0:
  - pop at edge 1;
  - `tx` falls after edge 2;
  - `tx` returns to 1 for the stop bit `9*CLKS_PER_BIT` cycles later.
- Back-to-back: with data queued and `busy_s`=0, the next start bit begins 1 cycle after the stop bit ends. Frame period is `10*CLKS_PER_BIT+1` cycles.
- `full` is registered: it rises the cycle after the write that fills the FIFO and falls the cycle after a pop from full.
- `avr_rx_busy` takes 2–3 cycles to take effect. A rise within that window before a pop may still allow one frame to start.
- `busy` is registered; it falls the cycle after the stop bit of the last queued byte ends.

## Structure
- Shared package `avr_serial_pkg`:
  - FSM state enum (`IDLE`, `START`, `DATA`, `STOP`);
  - `CLKS_PER_BIT` derivation function;
  - 8N1 frame constants (`START_BIT`=0, `STOP_BIT`=1, `DATA_BITS`=8).
- Sub-module `serial_tx_fifo`: synchronous single-clock FIFO with registered `full`/`empty` and the write-drop-on-full rule. Reusable later for an SPI response path.
- Top `avr_serial_tx` contains the synchronizer, FSM, bit timer and shift register.

## Test plan
- Single byte: after reset, write 0xA5 with `CLKS_PER_BIT`=100 → `tx` low at cycle 2, then bits 1,0,1,0,0,1,0,1 at 100-cycle spacing, then high; `busy` low at cycle 1003.
- Burst/full: write 17 bytes 0x00..0x10 on consecutive cycles → `full` high after the 16th accepted byte, 0x10 dropped; output bytes 0x00..0x0F with 1001-cycle frame spacing.
- Flow control: hold `avr_rx_busy`=1, write 0x3C → `tx` stays 1. Release → frame starts within 4 cycles. Raise busy mid-frame → that frame completes, the next does not start.
- Reset mid-frame: assert `rst` during bit 4 of 0xFF with 3 bytes queued → `tx`=1 on the next edge, `busy`=0, no further frames.
- Simultaneous write/pop: write exactly as the FSM pops with the FIFO holding 1 byte → both bytes transmitted in order, count correct.
